// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer and the program counter it drives:
// control states, PC update opcodes and the instruction-alignment rule.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_EXEC,
    ST_WRITE,
    ST_HALT,
    ST_FAULT
  } state_e;

  localparam logic [2:0]  PC_OP_INC = 3'd0;
  localparam logic [2:0]  PC_OP_REL = 3'd1;
  localparam logic [2:0]  PC_OP_ABS = 3'd2;

  localparam logic [31:0] INSTR_ALIGN_MASK = 32'h0000_0003;

  // Sequential updates carry no data, so only redirects can be misaligned.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [31:0] data);
    return (op != PC_OP_INC) && ((data & INSTR_ALIGN_MASK) != 32'd0);
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter control FSM: fetches at the current PC, holds the instruction
// for execute, then issues one PC update strobe per retired instruction.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 16,
  parameter int RETIRE_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         pcReadData,
  output logic                pcWriteEnable,
  output logic [2:0]          pcOp,
  output logic [31:0]         pcWriteData,
  output logic                imemReq,
  output logic [31:0]         imemAddr,
  input  logic                imemAck,
  input  logic [31:0]         imemData,
  output logic [31:0]         instr,
  output logic                instrValid,
  input  logic                execDone,
  input  logic                stall,
  input  logic                branchTaken,
  input  logic [31:0]         branchOffset,
  input  logic                jumpAbs,
  input  logic [31:0]         jumpTarget,
  input  logic                halt,
  output logic                halted,
  output logic                fault,
  output logic [31:0]         faultPc,
  output logic [RETIRE_W-1:0] retired
);

  state_e                state_q,   state_d;
  logic [7:0]            tmo_q,     tmo_d;
  logic [31:0]           instr_q,   instr_d;
  logic [2:0]            op_q,      op_d;
  logic [31:0]           data_q,    data_d;
  logic                  halt_q,    halt_d;
  logic [31:0]           fault_pc_q, fault_pc_d;
  logic [RETIRE_W-1:0]   retired_q, retired_d;

  logic [2:0]            sel_op;
  logic [31:0]           sel_data;

  always_comb begin
    if (jumpAbs) begin
      sel_op   = PC_OP_ABS;
      sel_data = jumpTarget;
    end else if (branchTaken) begin
      sel_op   = PC_OP_REL;
      sel_data = branchOffset;
    end else begin
      sel_op   = PC_OP_INC;
      sel_data = 32'd0;
    end
  end

  // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    tmo_d      = 8'd0;
    instr_d    = instr_q;
    op_d       = op_q;
    data_d     = data_q;
    halt_d     = halt_q;
    fault_pc_d = fault_pc_q;
    retired_d  = retired_q;

    unique case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (imemAck) begin
          instr_d = imemData;
          state_d = ST_EXEC;
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_d == 8'(FETCH_TIMEOUT)) begin
            state_d    = ST_FAULT;
            fault_pc_d = pcReadData;
          end
        end
      end
      ST_EXEC: begin
        if (execDone && !stall) begin
          if (is_misaligned(sel_op, sel_data)) begin
            state_d    = ST_FAULT;
            fault_pc_d = pcReadData;
          end else begin
            op_d      = sel_op;
            data_d    = sel_data;
            retired_d = retired_q + 1'b1;
            halt_d    = halt;
            state_d   = ST_WRITE;
          end
        end
      end
      ST_WRITE: state_d = halt_q ? ST_HALT : ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      tmo_q      <= 8'd0;
      instr_q    <= 32'd0;
      op_q       <= PC_OP_INC;
      data_q     <= 32'd0;
      halt_q     <= 1'b0;
      fault_pc_q <= 32'd0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      instr_q    <= instr_d;
      op_q       <= op_d;
      data_q     <= data_d;
      halt_q     <= halt_d;
      fault_pc_q <= fault_pc_d;
      retired_q  <= retired_d;
    end
  end

  // Strobes decode straight from the state register, so they drop the instant reset hits.
  assign imemReq       = (state_q == ST_FETCH);
  assign imemAddr      = imemReq ? pcReadData : 32'd0;
  assign instrValid    = (state_q == ST_EXEC);
  assign pcWriteEnable = (state_q == ST_WRITE);
  assign halted        = (state_q == ST_HALT);
  assign fault         = (state_q == ST_FAULT);
  assign pcOp          = op_q;
  assign pcWriteData   = data_q;
  assign instr         = instr_q;
  assign faultPc       = fault_pc_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, randomized
// instruction stream against a PC model, and multi-cycle corner sequences.
module tb_pc_sequencer;

  localparam int FETCH_TIMEOUT = 16;
  localparam int RETIRE_W      = 32;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [31:0]         pcReadData;
  logic                pcWriteEnable;
  logic [2:0]          pcOp;
  logic [31:0]         pcWriteData;
  logic                imemReq;
  logic [31:0]         imemAddr;
  logic                imemAck = 1'b0;
  logic [31:0]         imemData = 32'd0;
  logic [31:0]         instr;
  logic                instrValid;
  logic                execDone = 1'b0;
  logic                stall = 1'b0;
  logic                branchTaken = 1'b0;
  logic [31:0]         branchOffset = 32'd0;
  logic                jumpAbs = 1'b0;
  logic [31:0]         jumpTarget = 32'd0;
  logic                halt = 1'b0;
  logic                halted;
  logic                fault;
  logic [31:0]         faultPc;
  logic [RETIRE_W-1:0] retired;

  pc_sequencer #(.FETCH_TIMEOUT(FETCH_TIMEOUT), .RETIRE_W(RETIRE_W)) dut (
    .clk(clk), .reset(reset), .pcReadData(pcReadData),
    .pcWriteEnable(pcWriteEnable), .pcOp(pcOp), .pcWriteData(pcWriteData),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .instr(instr), .instrValid(instrValid), .execDone(execDone), .stall(stall),
    .branchTaken(branchTaken), .branchOffset(branchOffset), .jumpAbs(jumpAbs),
    .jumpTarget(jumpTarget), .halt(halt), .halted(halted), .fault(fault),
    .faultPc(faultPc), .retired(retired)
  );

  always #5 clk = ~clk;

  // Program counter the sequencer drives.
  logic [31:0] pc_init = 32'd0;
  always @(posedge clk or posedge reset) begin
    if (reset) pcReadData <= pc_init;
    else if (pcWriteEnable) begin
      case (pcOp)
        3'd0:    pcReadData <= pcReadData + 32'd4;
        3'd1:    pcReadData <= pcReadData + pcWriteData;
        3'd2:    pcReadData <= pcWriteData;
        default: pcReadData <= pcReadData;
      endcase
    end
  end

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_retired = 32'd0;
  logic [31:0] model_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imemReq && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'd0, imemReq}, 32'd1);
  endtask

  // Reference: what a retire with these inputs must do to the PC.
  task automatic ref_update(input logic j, input logic [31:0] tgt, input logic b,
                            input logic [31:0] off, input logic [31:0] pc,
                            output logic [2:0] op, output logic [31:0] data,
                            output logic [31:0] next_pc);
    if (j)      begin op = 3'd2; data = tgt; next_pc = tgt;      end
    else if (b) begin op = 3'd1; data = off; next_pc = pc + off; end
    else        begin op = 3'd0; data = 0;   next_pc = pc + 4;   end
  endtask

  task automatic run_instr(input logic j, input logic [31:0] tgt, input logic b,
                           input logic [31:0] off, input logic h, input int stalls,
                           input logic [2:0] exp_op, input logic [31:0] exp_data,
                           input logic [31:0] exp_addr);
    logic [31:0] word;
    wait_req();
    check("imem_addr", imemAddr, exp_addr);
    word = $urandom;
    imemData = word;
    imemAck  = 1'b1;
    @(negedge clk);
    imemAck  = 1'b0;
    imemData = $urandom;
    check("instr", instr, word);
    check("instr_valid", {31'd0, instrValid}, 32'd1);
    for (int s = 0; s < stalls; s++) begin
      execDone = 1'b1; stall = 1'b1; jumpAbs = j; jumpTarget = tgt;
      branchTaken = b; branchOffset = off;
      @(negedge clk);
      check("stall_no_write", {31'd0, pcWriteEnable}, 32'd0);
      check("stall_valid", {31'd0, instrValid}, 32'd1);
    end
    execDone = 1'b1; stall = 1'b0; jumpAbs = j; jumpTarget = tgt;
    branchTaken = b; branchOffset = off; halt = h;
    @(negedge clk);
    execDone = 1'b0; jumpAbs = 1'b0; branchTaken = 1'b0; halt = 1'b0;
    exp_retired = exp_retired + 1;
    check("write_en", {31'd0, pcWriteEnable}, 32'd1);
    check("pc_op", {29'd0, pcOp}, {29'd0, exp_op});
    check("pc_data", pcWriteData, exp_data);
    check("retired", retired, exp_retired);
    check("valid_drop", {31'd0, instrValid}, 32'd0);
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    pc_init = start_pc;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_retired = 32'd0;
    model_pc = start_pc;
  endtask

  typedef struct {
    logic        j;
    logic [31:0] tgt;
    logic        b;
    logic [31:0] off;
    logic [2:0]  op;
    logic [31:0] data;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int pulses;
    int cycles;
    logic [2:0]  r_op;
    logic [31:0] r_data, r_next, r_tgt, r_off;
    logic        r_j, r_b;

    vecs[0] = '{1'b0, 32'h0,   1'b0, 32'h0,        3'd0, 32'h0,        32'h000};
    vecs[1] = '{1'b1, 32'h10,  1'b0, 32'h0,        3'd2, 32'h10,       32'h004};
    vecs[2] = '{1'b0, 32'h0,   1'b1, 32'hFFFFFFF8, 3'd1, 32'hFFFFFFF8, 32'h010};
    vecs[3] = '{1'b1, 32'h100, 1'b1, 32'h40,       3'd2, 32'h100,      32'h008};
    vecs[4] = '{1'b0, 32'h0,   1'b1, 32'h20,       3'd1, 32'h20,       32'h100};
    vecs[5] = '{1'b0, 32'h0,   1'b0, 32'h0,        3'd0, 32'h0,        32'h120};

    // Reset state while reset is held.
    @(negedge clk);
    check("rst_req", {31'd0, imemReq}, 32'd0);
    check("rst_we", {31'd0, pcWriteEnable}, 32'd0);
    check("rst_flags", {29'd0, instrValid, halted, fault}, 32'd0);
    check("rst_retired", retired, 32'd0);
    do_reset(32'd0);

    for (int i = 0; i < 6; i++)
      run_instr(vecs[i].j, vecs[i].tgt, vecs[i].b, vecs[i].off, 1'b0, i % 2,
                vecs[i].op, vecs[i].data, vecs[i].addr);
    model_pc = 32'h124;

    // Randomized aligned instruction stream.
    for (int i = 0; i < 30; i++) begin
      r_j = ($urandom_range(0, 3) == 0);
      r_b = ($urandom_range(0, 1) == 1);
      r_tgt = $urandom & 32'hFFFF_FFFC;
      r_off = $urandom & 32'hFFFF_FFFC;
      ref_update(r_j, r_tgt, r_b, r_off, model_pc, r_op, r_data, r_next);
      run_instr(r_j, r_tgt, r_b, r_off, 1'b0, $urandom_range(0, 2), r_op, r_data, model_pc);
      model_pc = r_next;
    end

    // Asynchronous reset in the middle of a fetch.
    wait_req();
    check("pre_rst_addr", imemAddr, model_pc);
    pc_init = 32'd0;
    #2 reset = 1'b1;
    #1;
    check("async_req", {31'd0, imemReq}, 32'd0);
    check("async_retired", retired, 32'd0);
    check("async_instr", instr, 32'd0);
    check("async_op_data", pcWriteData | {29'd0, pcOp}, 32'd0);
    check("async_flags", {28'd0, pcWriteEnable, instrValid, halted, fault}, 32'd0);
    check("async_faultpc", faultPc, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_retired = 32'd0;
    model_pc = 32'd0;

    // Stall for three cycles, then retire with halt.
    run_instr(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 3, 3'd0, 32'd0, 32'd0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (pcWriteEnable) pulses++;
    end
    check("halt_extra_pulses", pulses, 32'd0);
    check("halted", {31'd0, halted}, 32'd1);
    check("halt_no_req", {31'd0, imemReq}, 32'd0);

    // Misaligned jump faults without a PC write.
    do_reset(32'h40);
    wait_req();
    check("mis_addr", imemAddr, 32'h40);
    imemAck = 1'b1;
    @(negedge clk);
    imemAck = 1'b0;
    execDone = 1'b1; jumpAbs = 1'b1; jumpTarget = 32'h102; branchTaken = 1'b1;
    branchOffset = 32'h8;
    @(negedge clk);
    execDone = 1'b0; jumpAbs = 1'b0; branchTaken = 1'b0;
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_faultpc", faultPc, 32'h40);
    check("mis_retired", retired, 32'd0);
    pulses = {31'd0, pcWriteEnable};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (pcWriteEnable) pulses++;
    end
    check("mis_no_write", pulses, 32'd0);
    check("mis_pc_kept", pcReadData, 32'h40);

    // Fetch timeout.
    do_reset(32'h80);
    wait_req();
    cycles = 0;
    while (!fault && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    check("timeout_cycles", cycles, FETCH_TIMEOUT);
    check("timeout_faultpc", faultPc, 32'h80);
    check("timeout_no_req", {31'd0, imemReq}, 32'd0);
    imemAck = 1'b1;
    @(negedge clk);
    imemAck = 1'b0;
    check("fault_sticky", {30'd0, fault, instrValid}, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control FSM that sequences the program counter. It issues instruction fetches at the current PC and holds the fetched instruction for execute.
- After each retire it drives a single-cycle PC update: sequential +4, relative branch, or absolute jump.
- Sits between the program counter, the instruction-memory port and the execute stage. It is the only source of pcWriteEnable, pcOp and pcWriteData.

Parameters:
- FETCH_TIMEOUT, 16, cycles in FETCH without imemAck before entering FAULT (legal range 1..255).
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- pcReadData  input  32  current PC from the program counter
- pcWriteEnable  output  1  PC update strobe, one cycle per retire
- pcOp  output  3  0 = PC+4, 1 = PC+pcWriteData, 2 = pcWriteData
- pcWriteData  output  32  branch offset or jump target; 0 for sequential
- imemReq  output  1  fetch request
- imemAddr  output  32  fetch address
- imemAck  input  1  fetch complete; imemData is valid in the same cycle
- imemData  input  32  fetched instruction
- instr  output  32  registered instruction
- instrValid  output  1  instr is valid for execute
- execDone  input  1  execute finished the current instruction
- stall  input  1  hold retire (hazard)
- branchTaken  input  1  relative redirect, sampled with execDone
- branchOffset  input  32  signed byte offset
- jumpAbs  input  1  absolute redirect, sampled with execDone
- jumpTarget  input  32  absolute byte address
- halt  input  1  stop after the current instruction retires
- halted  output  1  high in HALT
- fault  output  1  high in FAULT
- faultPc  output  32  PC latched on fault entry
- retired  output  RETIRE_W  count of retired instructions

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-fetch or mid-write):
  - state = BOOT.
  - All outputs 0: imemReq, pcWriteEnable, pcOp, pcWriteData, instr, instrValid, halted, fault, faultPc, retired.
  - The timeout counter is cleared.
- States: BOOT, FETCH, EXEC, WRITE, HALT, FAULT.
- BOOT: one cycle, then FETCH.
- FETCH:
  - imemReq = 1 and imemAddr = pcReadData, both held stable until imemAck.
  - On imemAck: instr <= imemData, clear the timeout counter, go to EXEC.
  - Without imemAck: the counter increments. When it reaches FETCH_TIMEOUT, go to FAULT with faultPc <= pcReadData.
- EXEC:
  - instrValid = 1 throughout.
  - The cycle with execDone = 1 and stall = 0 is the retire cycle. execDone is ignored while stall = 1.
  - Target selection on retire, by priority:
    - jumpAbs: op 2, data jumpTarget.
    - otherwise branchTaken: op 1, data branchOffset.
    - otherwise: op 0, data 0.
  - Misaligned target: bits [1:0] of the selected data are nonzero for op 1 or op 2. Go to FAULT, faultPc <= pcReadData, no PC write, retired unchanged.
  - Otherwise register op/data, retired <= retired + 1 (wraps modulo 2^RETIRE_W), latch halt, go to WRITE.
  - instrValid drops on the cycle after retire.
- WRITE:
  - pcWriteEnable = 1 for exactly this cycle, with the registered pcOp/pcWriteData.
  - The PC updates at the end of this cycle.
  - Next state: HALT if halt was latched, else FETCH. FETCH therefore sees the new PC.
- Retire-to-next-request latency: 2 cycles (the EXEC retire cycle, then WRITE).
- HALT: halted = 1, no requests. Exit only by reset.
- FAULT: fault = 1, no requests, faultPc frozen. Exit only by reset.
- Input qualification:
  - imemAck outside FETCH is ignored.
  - execDone, branchTaken, jumpAbs and halt outside EXEC are ignored.
  - pcWriteEnable is never high outside WRITE.

Decomposition:
- Shared package:
  - State enum.
  - PC op constants PC_OP_INC = 0, PC_OP_REL = 1, PC_OP_ABS = 2, used by both this block and the program counter.
  - Instruction-alignment mask constant.
- Sub-modules: none required. The timeout counter and retire counter stay inline.

Test Plan:
- Sequential, PC = 0:
  - Stimulus: imemAck 1 cycle after request; execDone with no redirect.
  - Required: pcWriteEnable with pcOp = 0 in WRITE; next imemAddr = 4; retired = 1.
- Branch, PC = 0x10:
  - Stimulus: branchTaken = 1, branchOffset = 0xFFFFFFF8, with execDone.
  - Required: pcOp = 1, pcWriteData = 0xFFFFFFF8; next fetch at 0x08.
- Priority:
  - Stimulus: jumpAbs = 1 (jumpTarget = 0x100) and branchTaken = 1 together.
  - Required: pcOp = 2, next fetch 0x100.
- Misaligned jump:
  - Stimulus: jumpTarget = 0x102.
  - Required: FAULT, no pcWriteEnable pulse, faultPc = current PC.
- Timeout:
  - Stimulus: imemAck never asserted.
  - Required: fault = 1 exactly FETCH_TIMEOUT cycles after imemReq rises.
- Stall, then halt, then reset:
  - Stimulus: execDone with stall = 1 for 3 cycles, then stall = 0 with halt = 1.
  - Required: a single write pulse, then halted = 1.
  - Stimulus: reset asserted mid-FETCH.
  - Required: imemReq drops immediately, all outputs return to 0.
